// File: rtl/ipsxb_qsgmii_pcs_tx_mux_v2_0.sv
// QSGMII-family PCS transmit multiplexer: accepts one byte group per port, applies idle
// fill and the lane-0 K28.1 marker, and serialises the group onto an OUT_BYTES-wide stream.
module ipsxb_qsgmii_pcs_tx_mux_v2_0 #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned OUT_BYTES = 4,
    parameter int unsigned K281_EN   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   port_en,
    input  logic [8*NUM_PORTS-1:0] in_txd,
    input  logic [NUM_PORTS-1:0]   in_txk,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*OUT_BYTES-1:0] out_txd,
    output logic [OUT_BYTES-1:0]   out_txk,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   underrun,
    output logic [15:0]            underrun_cnt,
    input  logic                   clr_cnt
);

    localparam int unsigned BEATS = NUM_PORTS / OUT_BYTES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {START, RUN} state_e;

    state_e                 state_q;
    logic [BW-1:0]          beat_cnt_q;
    logic                   idle_tgl_q;
    logic [8*NUM_PORTS-1:0] grp_txd_q, grp_txd_d;
    logic [NUM_PORTS-1:0]   grp_txk_q, grp_txk_d;
    logic [8*OUT_BYTES-1:0] out_txd_q, beat_txd;
    logic [OUT_BYTES-1:0]   out_txk_q, beat_txk;
    logic                   out_valid_q, out_sof_q, underrun_q;
    logic [15:0]            underrun_cnt_q;
    logic                   load, fill;
    logic [7:0]             idle_byte;
    logic                   idle_k;

    // Every edge at which in_ready is high reloads the group, accepted or not.
    assign in_ready = (state_q == START) || (beat_cnt_q == LAST_BEAT);
    assign load     = in_ready;
    assign fill     = load && !in_valid;

    always_comb begin
        idle_byte = idle_tgl_q ? 8'h50 : 8'hBC;
        idle_k    = ~idle_tgl_q;
        grp_txd_d = '0;
        grp_txk_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (in_valid && port_en[p]) begin
                grp_txd_d[8*p +: 8] = in_txd[8*p +: 8];
                grp_txk_d[p]        = in_txk[p];
            end else begin
                grp_txd_d[8*p +: 8] = idle_byte;
                grp_txk_d[p]        = idle_k;
            end
        end
        if (K281_EN != 0 && grp_txk_d[0] && grp_txd_d[7:0] == 8'hBC) begin
            grp_txd_d[7:0] = 8'h3C;
        end
    end

    always_comb begin
        beat_txd = '0;
        beat_txk = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == BW'(b)) begin
                beat_txd = grp_txd_q[b*8*OUT_BYTES +: 8*OUT_BYTES];
                beat_txk = grp_txk_q[b*OUT_BYTES +: OUT_BYTES];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= START;
            beat_cnt_q     <= '0;
            idle_tgl_q     <= 1'b0;
            grp_txd_q      <= '0;
            grp_txk_q      <= '0;
            out_txd_q      <= '0;
            out_txk_q      <= '0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun_q <= fill;
            if (clr_cnt) begin
                underrun_cnt_q <= '0;
            end else if (fill && underrun_cnt_q != '1) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
            if (load) begin
                grp_txd_q  <= grp_txd_d;
                grp_txk_q  <= grp_txk_d;
                idle_tgl_q <= ~idle_tgl_q;
            end
            case (state_q)
                START: begin
                    state_q    <= RUN;
                    beat_cnt_q <= '0;
                end
                RUN: begin
                    out_txd_q   <= beat_txd;
                    out_txk_q   <= beat_txk;
                    out_valid_q <= 1'b1;
                    out_sof_q   <= (beat_cnt_q == '0);
                    beat_cnt_q  <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BW'(1);
                end
            endcase
        end
    end

    assign out_txd      = out_txd_q;
    assign out_txk      = out_txk_q;
    assign out_valid    = out_valid_q;
    assign out_sof      = out_sof_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_ipsxb_qsgmii_pcs_tx_mux_v2_0.sv
// Scoreboard bench for the PCS tx mux: three configurations (8/2 K28.1 on, 4/4 K28.1 on,
// 4/4 K28.1 off) share stimulus; each has its own reference model and expected-beat queue.
module tb_ipsxb_qsgmii_pcs_tx_mux_v2_0;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txk;
        logic        sof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  port_en;
    logic [63:0] in_txd;
    logic [7:0]  in_txk;
    logic        in_valid;
    logic        clr_cnt;

    logic [2:0]  rdy, ov, sof, ur;
    logic [15:0] a_txd;
    logic [1:0]  a_txk;
    logic [31:0] b_txd, c_txd;
    logic [3:0]  b_txk, c_txk;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    int          total = 0;
    int          bad   = 0;

    int          e[3];
    bit          tgl[3];
    logic [15:0] mcnt[3];
    bit          mur[3];
    bit          pop_exp[3];
    beat_t       sbq[3][$];

    always #5 clk = ~clk;

    ipsxb_qsgmii_pcs_tx_mux_v2_0 #(.NUM_PORTS(8), .OUT_BYTES(2), .K281_EN(1)) u_a (
        .clk(clk), .rst(rst), .port_en(port_en), .in_txd(in_txd), .in_txk(in_txk),
        .in_valid(in_valid), .in_ready(rdy[0]), .out_txd(a_txd), .out_txk(a_txk),
        .out_valid(ov[0]), .out_sof(sof[0]), .underrun(ur[0]), .underrun_cnt(a_cnt),
        .clr_cnt(clr_cnt)
    );

    ipsxb_qsgmii_pcs_tx_mux_v2_0 #(.NUM_PORTS(4), .OUT_BYTES(4), .K281_EN(1)) u_b (
        .clk(clk), .rst(rst), .port_en(port_en[3:0]), .in_txd(in_txd[31:0]), .in_txk(in_txk[3:0]),
        .in_valid(in_valid), .in_ready(rdy[1]), .out_txd(b_txd), .out_txk(b_txk),
        .out_valid(ov[1]), .out_sof(sof[1]), .underrun(ur[1]), .underrun_cnt(b_cnt),
        .clr_cnt(clr_cnt)
    );

    ipsxb_qsgmii_pcs_tx_mux_v2_0 #(.NUM_PORTS(4), .OUT_BYTES(4), .K281_EN(0)) u_c (
        .clk(clk), .rst(rst), .port_en(port_en[3:0]), .in_txd(in_txd[31:0]), .in_txk(in_txk[3:0]),
        .in_valid(in_valid), .in_ready(rdy[2]), .out_txd(c_txd), .out_txk(c_txk),
        .out_valid(ov[2]), .out_sof(sof[2]), .underrun(ur[2]), .underrun_cnt(c_cnt),
        .clr_cnt(clr_cnt)
    );

    function automatic int np_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic int ob_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit k281_of(input int d);
        return (d != 2);
    endfunction

    function automatic int beats_of(input int d);
        return np_of(d) / ob_of(d);
    endfunction

    function automatic logic [63:0] out_d(input int d);
        case (d)
            0:       return {48'h0, a_txd};
            1:       return {32'h0, b_txd};
            default: return {32'h0, c_txd};
        endcase
    endfunction

    function automatic logic [7:0] out_k(input int d);
        case (d)
            0:       return {6'h0, a_txk};
            1:       return {4'h0, b_txk};
            default: return {4'h0, c_txk};
        endcase
    endfunction

    function automatic logic [15:0] out_cnt(input int d);
        case (d)
            0:       return a_cnt;
            1:       return b_cnt;
            default: return c_cnt;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_group(input int d);
        logic [63:0] g;
        logic [7:0]  gk;
        beat_t       be;
        int          np, ob;
        np = np_of(d);
        ob = ob_of(d);
        g  = '0;
        gk = '0;
        for (int p = 0; p < np; p++) begin
            if (in_valid && port_en[p]) begin
                g[8*p +: 8] = in_txd[8*p +: 8];
                gk[p]       = in_txk[p];
            end else begin
                g[8*p +: 8] = tgl[d] ? 8'h50 : 8'hBC;
                gk[p]       = !tgl[d];
            end
        end
        if (k281_of(d) && gk[0] && g[7:0] == 8'hBC) g[7:0] = 8'h3C;
        tgl[d] = !tgl[d];
        for (int b = 0; b < np / ob; b++) begin
            be = '0;
            for (int j = 0; j < ob; j++) begin
                be.txd[8*j +: 8] = g[8*(b*ob+j) +: 8];
                be.txk[j]        = gk[b*ob+j];
            end
            be.sof = (b == 0);
            sbq[d].push_back(be);
        end
    endtask

    // Reference model: loads on every BEATS-th edge after reset release, starting with edge 0.
    always @(posedge clk or posedge rst) begin : model
        bit ld;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                e[d]       = 0;
                tgl[d]     = 1'b0;
                mcnt[d]    = '0;
                mur[d]     = 1'b0;
                pop_exp[d] = 1'b0;
                sbq[d].delete();
            end else begin
                ld         = (e[d] % beats_of(d)) == 0;
                pop_exp[d] = (e[d] >= 1);
                mur[d]     = ld && !in_valid;
                if (clr_cnt) mcnt[d] = '0;
                else if (ld && !in_valid && mcnt[d] != 16'hFFFF) mcnt[d] = mcnt[d] + 16'd1;
                if (ld) load_group(d);
                e[d] = e[d] + 1;
            end
        end
    end

    task automatic mon(input int d);
        beat_t be;
        chk($sformatf("d%0d_in_ready", d), rdy[d], (e[d] % beats_of(d)) == 0);
        chk($sformatf("d%0d_underrun", d), ur[d], mur[d]);
        chk($sformatf("d%0d_underrun_cnt", d), out_cnt(d), mcnt[d]);
        if (pop_exp[d]) begin
            if (sbq[d].size() == 0) begin
                chk($sformatf("d%0d_sb_empty", d), 1, 0);
            end else begin
                be = sbq[d].pop_front();
                chk($sformatf("d%0d_out_valid", d), ov[d], 1);
                chk($sformatf("d%0d_out_txd", d), out_d(d), be.txd);
                chk($sformatf("d%0d_out_txk", d), out_k(d), be.txk);
                chk($sformatf("d%0d_out_sof", d), sof[d], be.sof);
            end
        end else begin
            chk($sformatf("d%0d_out_valid_idle", d), ov[d], 0);
            chk($sformatf("d%0d_out_txd_idle", d), out_d(d), 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int d = 0; d < 3; d++) mon(d);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_d%0d_txd", tag, d), out_d(d), 0);
            chk($sformatf("%s_d%0d_txk", tag, d), out_k(d), 0);
            chk($sformatf("%s_d%0d_valid", tag, d), ov[d], 0);
            chk($sformatf("%s_d%0d_sof", tag, d), sof[d], 0);
            chk($sformatf("%s_d%0d_underrun", tag, d), ur[d], 0);
            chk($sformatf("%s_d%0d_cnt", tag, d), out_cnt(d), 0);
            chk($sformatf("%s_d%0d_ready", tag, d), rdy[d], 1);
        end
    endtask

    task automatic rand_data();
        for (int p = 0; p < 8; p++) begin
            in_txd[8*p +: 8] = ($urandom % 3 == 0) ? 8'hBC : 8'($urandom);
            in_txk[p]        = 1'($urandom % 2);
        end
    endtask

    initial begin
        port_en  = 8'hFF;
        in_txd   = 64'h8877665544332211;
        in_txk   = 8'h00;
        in_valid = 1'b1;
        clr_cnt  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Plain data on all ports.
        repeat (16) @(negedge clk);

        // K28.5 on ports 0, 2 and 4: only port 0 may become K28.1.
        in_txd = 64'h887766BC44BC22BC;
        in_txk = 8'b0001_0101;
        repeat (12) @(negedge clk);

        // Underrun fill, with a clear landing on an increment edge.
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;

        // Disabled ports with port_en wiggling between loads.
        in_txd = 64'hF0E0D0C0B0A09080;
        in_txk = 8'h00;
        for (int i = 0; i < 16; i++) begin
            port_en = (i % 3 == 1) ? 8'hFF : 8'hBB;
            @(negedge clk);
        end
        port_en = 8'hFF;

        // Asynchronous reset while the 8/2 instance is emitting beat 1.
        for (int i = 0; i < 8 && (e[0] % 4) != 3; i++) @(negedge clk);
        chk("mid_group_align", e[0] % 4, 3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Mixed random traffic.
        for (int i = 0; i < 200; i++) begin
            rand_data();
            in_valid = ($urandom % 5) != 0;
            clr_cnt  = ($urandom % 20) == 0;
            if ($urandom % 4 == 0) port_en = 8'($urandom);
            @(negedge clk);
        end
        clr_cnt = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ipsxb_qsgmii_pcs_tx_mux_v2_0.md
Name: ipsxb_qsgmii_pcs_tx_mux_v2_0

Overview:
Parametrised QSGMII-family PCS transmit multiplexer. It accepts one 8b/10b pre-encoded byte group (one byte plus K flag per port) through a valid/ready handshake. It applies per-port idle substitution and the lane-0 K28.5 to K28.1 alignment marker, then serialises the group onto an OUT_BYTES-wide continuous stream toward the SerDes encoder. It replaces the fixed 4-port/32-bit adapt+switch pair and adds port count, output width, underrun idle fill and status.

Parameters:
NUM_PORTS, 4, number of multiplexed ports; legal values 1, 2, 4, 8.
OUT_BYTES, 4, bytes emitted per clk; legal values 1, 2, 4, 8; must be ≤ NUM_PORTS and divide it.
K281_EN, 1, 1 = replace K28.5 on port 0 with K28.1; 0 = pass unchanged.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
port_en  in  NUM_PORTS  per-port enable; a disabled port transmits idle.
in_txd  in  8*NUM_PORTS  group data; port p occupies bits [8p+7:8p].
in_txk  in  NUM_PORTS  group K flags; bit p belongs to port p.
in_valid  in  1  group presented.
in_ready  out  1  group accepted at the rising edge when in_valid and in_ready are both 1.
out_txd  out  8*OUT_BYTES  output bytes; lowest port of the beat in byte lane 0.
out_txk  out  OUT_BYTES  output K flags.
out_valid  out  1  output beat valid.
out_sof  out  1  high on the beat carrying port 0.
underrun  out  1  one-cycle pulse when an idle group is auto-inserted.
underrun_cnt  out  16  saturating count of inserted groups.
clr_cnt  in  1  synchronous clear of underrun_cnt.

Behaviour:
- BEATS = NUM_PORTS/OUT_BYTES. Beat b carries ports b*OUT_BYTES .. b*OUT_BYTES+OUT_BYTES-1.
- Reset values: out_txd=0, out_txk=0, out_valid=0, out_sof=0, underrun=0, underrun_cnt=0, beat_cnt=0, idle toggle=0, state=START.
- in_ready is decoded from state and beat_cnt only and never depends on in_valid. It is 1 in START, or in RUN when beat_cnt==BEATS-1. With BEATS=1 it is constantly 1 in RUN.
- START: lasts the single cycle after rst deasserts. A group is loaded at the edge, then state goes to RUN with beat_cnt=0.
- Loading a group at any load edge:
  - If in_valid=1, take in_txd/in_txk.
  - If in_valid=0, load an all-idle group; pulse underrun the next cycle and increment underrun_cnt, saturating at 0xFFFF.
  - port_en is sampled at the load edge. Every disabled port's byte is replaced by idle, even when in_valid=1.
- Idle byte: the idle toggle selects K28.5 (0xBC, k=1) when 0 and D16.2 (0x50, k=0) when 1. The toggle flips on every load edge, so all idle ports in a group carry the same symbol.
- K28.1 substitution: with K281_EN=1, a port-0 byte equal to 0xBC with k=1, whether user data or idle, is emitted as 0x3C with k=1. No other port and no k=0 byte is ever altered.
- RUN:
  - Each cycle register beat beat_cnt of the held group onto out_txd/out_txk; out_valid=1.
  - out_sof=1 when the emitted beat is beat 0.
  - beat_cnt increments and wraps from BEATS-1 to 0; the wrap edge is the next load edge.
- Latency: a group accepted at edge t emits beat 0 at the output after edge t+1. Throughput is one group per BEATS cycles with no bubbles; out_valid stays 1 continuously from the first beat until reset.
- Downstream has no backpressure; the stream is never stalled.
- clr_cnt has priority over an increment in the same cycle: the counter goes to 0 and that increment is lost. The underrun pulse still fires.
- Reset mid-group: all state returns to reset values and the partially sent group is discarded. After release the block starts again from START.
- port_en changes take effect only at the next load edge; a group already in progress is never modified.

Test Plan:
- NUM_PORTS=4, OUT_BYTES=4, all enabled, in_valid=1 with groups {0x11,0x22,0x33,0x44} k=0 -> out_txd=0x44332211, out_sof=1 every cycle, in_ready=1, underrun never pulses, first beat at the 2nd edge after rst release.
- Same config, port 0 sends 0xBC k=1, port 2 sends 0xBC k=1 -> out_txd=0x44BC223C with out_txk=0b0101. With K281_EN=0 the byte-0 value is 0xBC.
- NUM_PORTS=8, OUT_BYTES=2 -> in_ready high exactly 1 cycle in 4; out_sof on every 4th beat; beats carry ports {0,1},{2,3},{4,5},{6,7} in order.
- Hold in_valid=0 for 3 load edges -> 3 underrun pulses, underrun_cnt=3, groups alternate all-K28.5 (port 0 as 0x3C) then all-D16.2 0x50. Then clr_cnt=1 -> underrun_cnt=0.
- port_en=0b1011 with valid data -> port 2 emits idle alternating 0xBC and 0x50 across groups while ports 0, 1 and 3 carry data. Toggling port_en mid-group has no effect until the next load.
- Assert rst during beat 1 of a BEATS=4 group -> all outputs return to 0 immediately (asynchronous). After release, out_valid resumes with out_sof=1 on the first beat.
